// File: rtl/axi3_wr_xbar.sv
// axi3_wr_xbar: AXI3 write-channel (AW/W/B) crossbar, NUM_M masters to NUM_S slaves.
// Each slave port owns a round-robin arbiter and a transaction lock held from
// the granted master's AW request until its B handshake. Bursts pass through
// intact and terminate on WLAST. Ready/valid paths are combinational muxes
// steered by the registered grant.
// Optional feature macro: AXI3_WR_XBAR_DECERR_EN adds an internal decode-error
// slave at index NUM_S; without it unmapped addresses go to slave NUM_S-1.
module axi3_wr_xbar #(
    parameter int NUM_M   = 2,
    parameter int NUM_S   = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_LSB = 28
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [NUM_M*ADDR_W-1:0]   M_AWADDR_i,
    input  logic [NUM_M*4-1:0]        M_AWLEN_i,
    input  logic [NUM_M*3-1:0]        M_AWSIZE_i,
    input  logic [NUM_M*2-1:0]        M_AWBURST_i,
    input  logic [NUM_M-1:0]          M_AWVALID_i,
    output logic [NUM_M-1:0]          M_AWREADY_o,
    input  logic [NUM_M*DATA_W-1:0]   M_WDATA_i,
    input  logic [NUM_M*DATA_W/8-1:0] M_WSTRB_i,
    input  logic [NUM_M-1:0]          M_WLAST_i,
    input  logic [NUM_M-1:0]          M_WVALID_i,
    output logic [NUM_M-1:0]          M_WREADY_o,
    output logic [NUM_M*2-1:0]        M_BRESP_o,
    output logic [NUM_M-1:0]          M_BVALID_o,
    input  logic [NUM_M-1:0]          M_BREADY_i,
    output logic [NUM_S*ADDR_W-1:0]   S_AWADDR_o,
    output logic [NUM_S*4-1:0]        S_AWLEN_o,
    output logic [NUM_S*3-1:0]        S_AWSIZE_o,
    output logic [NUM_S*2-1:0]        S_AWBURST_o,
    output logic [NUM_S-1:0]          S_AWVALID_o,
    input  logic [NUM_S-1:0]          S_AWREADY_i,
    output logic [NUM_S*DATA_W-1:0]   S_WDATA_o,
    output logic [NUM_S*DATA_W/8-1:0] S_WSTRB_o,
    output logic [NUM_S-1:0]          S_WLAST_o,
    output logic [NUM_S-1:0]          S_WVALID_o,
    input  logic [NUM_S-1:0]          S_WREADY_i,
    input  logic [NUM_S*2-1:0]        S_BRESP_i,
    input  logic [NUM_S-1:0]          S_BVALID_i,
    output logic [NUM_S-1:0]          S_BREADY_o
);

    localparam int SW = DATA_W / 8;
    localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
`ifdef AXI3_WR_XBAR_DECERR_EN
    localparam int NT = NUM_S + 1;  // last target is the internal decode-error slave
`else
    localparam int NT = NUM_S;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} st_e;

    st_e             st_q [NT];
    logic [MW-1:0]   g_q  [NT];
    logic [MW-1:0]   rr_q [NT];

    logic [3:0]      tgt_s      [NUM_M];
    logic            busy_s     [NUM_M];
    logic [MW-1:0]   win_s      [NT];
    logic            win_vld_s  [NT];
    logic            aw_rdy_s   [NT];
    logic            w_rdy_s    [NT];
    logic            b_vld_s    [NT];
    logic [1:0]      b_resp_s   [NT];
    logic            aw_hs_s    [NT];
    logic            wl_hs_s    [NT];
    logic            b_hs_s     [NT];

    // Map an AW address onto a target index; out-of-range selects are unmapped.
    function automatic logic [3:0] decode(input logic [ADDR_W-1:0] addr);
        logic [3:0] sel;
        sel = addr[SEL_LSB+3:SEL_LSB];
        if (int'(sel) < NUM_S) begin
            return sel;
        end else begin
`ifdef AXI3_WR_XBAR_DECERR_EN
            return 4'(NUM_S);
`else
            return 4'(NUM_S - 1);
`endif
        end
    endfunction

    // Per-master target decode and busy flag (busy while any target holds its grant).
    always_comb begin
        for (int m = 0; m < NUM_M; m++) begin
            tgt_s[m]  = decode(M_AWADDR_i[m*ADDR_W +: ADDR_W]);
            busy_s[m] = 1'b0;
            for (int t = 0; t < NT; t++) begin
                busy_s[m] = busy_s[m] | ((st_q[t] != ST_IDLE) && (int'(g_q[t]) == m));
            end
        end
    end

    // Target-side ready/valid view, including the internal decode-error responder.
    always_comb begin
        for (int t = 0; t < NUM_S; t++) begin
            aw_rdy_s[t] = S_AWREADY_i[t];
            w_rdy_s[t]  = S_WREADY_i[t];
            b_vld_s[t]  = S_BVALID_i[t];
            b_resp_s[t] = S_BRESP_i[t*2 +: 2];
        end
`ifdef AXI3_WR_XBAR_DECERR_EN
        aw_rdy_s[NUM_S] = 1'b1;
        w_rdy_s[NUM_S]  = 1'b1;
        b_vld_s[NUM_S]  = 1'b1;
        b_resp_s[NUM_S] = 2'b11;
`endif
    end

    // Round-robin pick: first idle-capable requester at or after rr, wrapping.
    always_comb begin
        for (int t = 0; t < NT; t++) begin
            win_vld_s[t] = 1'b0;
            win_s[t]     = {MW{1'b0}};
            for (int i = 0; i < NUM_M; i++) begin
                int  idx;
                logic hit;
                idx          = (int'(rr_q[t]) + i) % NUM_M;
                hit          = !win_vld_s[t] && M_AWVALID_i[idx] && !busy_s[idx]
                               && (tgt_s[idx] == 4'(t));
                win_s[t]     = hit ? MW'(idx) : win_s[t];
                win_vld_s[t] = win_vld_s[t] | hit;
            end
        end
    end

    // Handshake detection on the granted master's channels per target.
    always_comb begin
        for (int t = 0; t < NT; t++) begin
            int gi;
            gi         = int'(g_q[t]);
            aw_hs_s[t] = (st_q[t] == ST_ADDR) && M_AWVALID_i[gi] && aw_rdy_s[t];
            wl_hs_s[t] = (st_q[t] == ST_DATA) && M_WVALID_i[gi] && w_rdy_s[t] && M_WLAST_i[gi];
            b_hs_s[t]  = (st_q[t] == ST_RESP) && b_vld_s[t] && M_BREADY_i[gi];
        end
    end

    // Per-target FSM, grant and round-robin pointer.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int t = 0; t < NT; t++) begin
                st_q[t] <= ST_IDLE;
                g_q[t]  <= {MW{1'b0}};
                rr_q[t] <= {MW{1'b0}};
            end
        end else begin
            for (int t = 0; t < NT; t++) begin
                case (st_q[t])
                    ST_IDLE: if (win_vld_s[t]) begin
                        g_q[t]  <= win_s[t];
                        st_q[t] <= ST_ADDR;
                    end
                    ST_ADDR: if (aw_hs_s[t]) st_q[t] <= ST_DATA;
                    ST_DATA: if (wl_hs_s[t]) st_q[t] <= ST_RESP;
                    ST_RESP: if (b_hs_s[t]) begin
                        rr_q[t] <= (int'(g_q[t]) == NUM_M - 1) ? {MW{1'b0}} : g_q[t] + MW'(1);
                        st_q[t] <= ST_IDLE;
                    end
                    default: st_q[t] <= ST_IDLE;
                endcase
            end
        end
    end

    // Steer master and slave channels through the granted path; everything else is 0.
    always_comb begin
        M_AWREADY_o = '0;
        M_WREADY_o  = '0;
        M_BVALID_o  = '0;
        M_BRESP_o   = '0;
        S_AWADDR_o  = '0;
        S_AWLEN_o   = '0;
        S_AWSIZE_o  = '0;
        S_AWBURST_o = '0;
        S_AWVALID_o = '0;
        S_WDATA_o   = '0;
        S_WSTRB_o   = '0;
        S_WLAST_o   = '0;
        S_WVALID_o  = '0;
        S_BREADY_o  = '0;
        for (int t = 0; t < NT; t++) begin
            int gi;
            gi = int'(g_q[t]);
            case (st_q[t])
                ST_ADDR: M_AWREADY_o[gi] = aw_rdy_s[t];
                ST_DATA: M_WREADY_o[gi]  = w_rdy_s[t];
                ST_RESP: begin
                    M_BVALID_o[gi]         = b_vld_s[t];
                    M_BRESP_o[gi*2 +: 2]   = b_resp_s[t];
                end
                default: ;
            endcase
        end
        for (int t = 0; t < NUM_S; t++) begin
            int gi;
            gi = int'(g_q[t]);
            case (st_q[t])
                ST_ADDR: begin
                    S_AWVALID_o[t]                = M_AWVALID_i[gi];
                    S_AWADDR_o[t*ADDR_W +: ADDR_W] = M_AWADDR_i[gi*ADDR_W +: ADDR_W];
                    S_AWLEN_o[t*4 +: 4]           = M_AWLEN_i[gi*4 +: 4];
                    S_AWSIZE_o[t*3 +: 3]          = M_AWSIZE_i[gi*3 +: 3];
                    S_AWBURST_o[t*2 +: 2]         = M_AWBURST_i[gi*2 +: 2];
                end
                ST_DATA: begin
                    S_WVALID_o[t]                  = M_WVALID_i[gi];
                    S_WDATA_o[t*DATA_W +: DATA_W]  = M_WDATA_i[gi*DATA_W +: DATA_W];
                    S_WSTRB_o[t*SW +: SW]          = M_WSTRB_i[gi*SW +: SW];
                    S_WLAST_o[t]                   = M_WLAST_i[gi];
                end
                ST_RESP: S_BREADY_o[t] = M_BREADY_i[gi];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi3_wr_xbar.sv
// Directed bench for axi3_wr_xbar (2 masters, 2 slaves, default parameters).
module tb_axi3_wr_xbar;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [63:0] M_AWADDR;
    logic [7:0]  M_AWLEN;
    logic [5:0]  M_AWSIZE;
    logic [3:0]  M_AWBURST;
    logic [1:0]  M_AWVALID, M_AWREADY;
    logic [63:0] M_WDATA;
    logic [7:0]  M_WSTRB;
    logic [1:0]  M_WLAST, M_WVALID, M_WREADY;
    logic [3:0]  M_BRESP;
    logic [1:0]  M_BVALID, M_BREADY;
    logic [63:0] S_AWADDR;
    logic [7:0]  S_AWLEN;
    logic [5:0]  S_AWSIZE;
    logic [3:0]  S_AWBURST;
    logic [1:0]  S_AWVALID, S_AWREADY;
    logic [63:0] S_WDATA;
    logic [7:0]  S_WSTRB;
    logic [1:0]  S_WLAST, S_WVALID, S_WREADY;
    logic [3:0]  S_BRESP;
    logic [1:0]  S_BVALID, S_BREADY;

    int n_tests = 0;
    int n_fail  = 0;

    axi3_wr_xbar dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .M_AWADDR_i(M_AWADDR), .M_AWLEN_i(M_AWLEN), .M_AWSIZE_i(M_AWSIZE),
        .M_AWBURST_i(M_AWBURST), .M_AWVALID_i(M_AWVALID), .M_AWREADY_o(M_AWREADY),
        .M_WDATA_i(M_WDATA), .M_WSTRB_i(M_WSTRB), .M_WLAST_i(M_WLAST),
        .M_WVALID_i(M_WVALID), .M_WREADY_o(M_WREADY),
        .M_BRESP_o(M_BRESP), .M_BVALID_o(M_BVALID), .M_BREADY_i(M_BREADY),
        .S_AWADDR_o(S_AWADDR), .S_AWLEN_o(S_AWLEN), .S_AWSIZE_o(S_AWSIZE),
        .S_AWBURST_o(S_AWBURST), .S_AWVALID_o(S_AWVALID), .S_AWREADY_i(S_AWREADY),
        .S_WDATA_o(S_WDATA), .S_WSTRB_o(S_WSTRB), .S_WLAST_o(S_WLAST),
        .S_WVALID_o(S_WVALID), .S_WREADY_i(S_WREADY),
        .S_BRESP_i(S_BRESP), .S_BVALID_i(S_BVALID), .S_BREADY_o(S_BREADY)
    );

    always #5 ACLK = ~ACLK;

    // Always-ready slave models; B is returned the cycle after the WLAST beat.
    logic [1:0]  s_bvld_q;
    int          cyc = 0;
    int          aw_cnt[2]   = '{0, 0};
    int          beat_cnt[2] = '{0, 0};
    int          last_cnt[2] = '{0, 0};
    int          b_cnt[2]    = '{0, 0};
    int          act_cnt[2]  = '{0, 0};
    int          cur_beats[2] = '{0, 0};
    int          seen_len[2] = '{0, 0};
    logic [31:0] aw_addr_q[2];
    logic [3:0]  aw_len_q[2];
    logic [31:0] wdata_q[2];

    assign S_AWREADY = 2'b11;
    assign S_WREADY  = 2'b11;
    assign S_BRESP   = 4'b0000;
    assign S_BVALID  = s_bvld_q;

    always_ff @(posedge ACLK) cyc <= cyc + 1;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            s_bvld_q  <= 2'b00;
            cur_beats <= '{0, 0};
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (S_AWVALID[s] || S_WVALID[s] || S_BREADY[s]) act_cnt[s] <= act_cnt[s] + 1;
                if (S_AWVALID[s] && S_AWREADY[s]) begin
                    aw_cnt[s]    <= aw_cnt[s] + 1;
                    aw_addr_q[s] <= S_AWADDR[s*32 +: 32];
                    aw_len_q[s]  <= S_AWLEN[s*4 +: 4];
                end
                if (S_WVALID[s] && S_WREADY[s]) begin
                    beat_cnt[s] <= beat_cnt[s] + 1;
                    wdata_q[s]  <= S_WDATA[s*32 +: 32];
                    if (S_WLAST[s]) begin
                        last_cnt[s]  <= last_cnt[s] + 1;
                        seen_len[s]  <= cur_beats[s] + 1;
                        cur_beats[s] <= 0;
                        s_bvld_q[s]  <= 1'b1;
                    end else begin
                        cur_beats[s] <= cur_beats[s] + 1;
                    end
                end else if (s_bvld_q[s] && S_BREADY[s]) begin
                    s_bvld_q[s] <= 1'b0;
                    b_cnt[s]    <= b_cnt[s] + 1;
                end
            end
        end
    end

    int          aw_cyc[2];
    int          b_cyc[2];
    logic [1:0]  b_resp[2];
    logic [1:0]  b_done;
    int          start_cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctrl"}, {50'd0, M_AWREADY, M_WREADY, M_BVALID, M_BRESP, S_AWVALID, S_WVALID, S_BREADY}, 64'd0);
        chk({tag, "_payload"}, {63'd0, (|S_AWADDR) | (|S_AWLEN) | (|S_AWSIZE) | (|S_AWBURST)
                                       | (|S_WDATA) | (|S_WSTRB) | (|S_WLAST)}, 64'd0);
    endtask

    task automatic clear_masters();
        M_AWADDR = '0; M_AWLEN = '0; M_AWSIZE = '0; M_AWBURST = '0; M_AWVALID = '0;
        M_WDATA = '0; M_WSTRB = '0; M_WLAST = '0; M_WVALID = '0;
    endtask

    // Drive one write on each enabled master (AW and first W beat together) until B.
    task automatic run_writes(input logic [1:0] en,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [3:0] l0, input logic [3:0] l1,
                              input logic [31:0] d0, input logic [31:0] d1);
        logic [31:0] addr[2], base[2];
        logic [3:0]  len[2];
        int          beat[2];
        logic        awf[2], wf[2], bf[2];
        addr = '{a0, a1}; len = '{l0, l1}; base = '{d0, d1};
        @(negedge ACLK);
        start_cyc = cyc;
        b_done    = ~en;
        for (int m = 0; m < 2; m++) begin
            beat[m] = 0;
            if (en[m]) begin
                M_AWADDR[m*32 +: 32] = addr[m];
                M_AWLEN[m*4 +: 4]    = len[m];
                M_AWSIZE[m*3 +: 3]   = 3'd2;
                M_AWBURST[m*2 +: 2]  = 2'b01;
                M_AWVALID[m]         = 1'b1;
                M_WDATA[m*32 +: 32]  = base[m];
                M_WSTRB[m*4 +: 4]    = 4'hF;
                M_WLAST[m]           = (len[m] == 4'd0);
                M_WVALID[m]          = 1'b1;
            end
        end
        #1;
        for (int n = 0; n < 60 && b_done != 2'b11; n++) begin
            for (int m = 0; m < 2; m++) begin
                awf[m] = M_AWVALID[m] && M_AWREADY[m];
                wf[m]  = M_WVALID[m] && M_WREADY[m];
                bf[m]  = M_BVALID[m] && M_BREADY[m] && !b_done[m];
                if (awf[m]) aw_cyc[m] = cyc;
                if (bf[m]) begin
                    b_cyc[m]  = cyc;
                    b_resp[m] = M_BRESP[m*2 +: 2];
                end
            end
            @(posedge ACLK);
            #1;
            for (int m = 0; m < 2; m++) begin
                if (awf[m]) M_AWVALID[m] = 1'b0;
                if (wf[m]) begin
                    if (M_WLAST[m]) begin
                        M_WVALID[m] = 1'b0;
                        M_WLAST[m]  = 1'b0;
                    end else begin
                        beat[m]             = beat[m] + 1;
                        M_WDATA[m*32 +: 32] = base[m] + beat[m];
                        M_WLAST[m]          = (beat[m] == int'(len[m]));
                    end
                end
                if (bf[m]) b_done[m] = 1'b1;
            end
            @(negedge ACLK);
        end
        chk("completion", {62'd0, b_done}, 64'd3);
        clear_masters();
    endtask

    int snap_aw0, snap_aw1, snap_act0, snap_act1, snap_beat, snap_last, snap_b, snap_b0;

    initial begin
        ARESETn  = 1'b0;
        M_BREADY = 2'b11;
        clear_masters();
        repeat (3) @(negedge ACLK);
        chk_idle("in_reset");
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk_idle("after_reset");

        // Contention on S0 with fresh pointers: M0 first, M1 right after M0's B.
        run_writes(2'b11, 32'h0000_0020, 32'h0000_0030, 4'd0, 4'd0, 32'hA0, 32'hB0);
        chk("cont1_m0_first", {63'd0, aw_cyc[0] < aw_cyc[1]}, 64'd1);
        chk("cont1_m1_gap", aw_cyc[1], b_cyc[0] + 2);
        chk("cont1_resp", {b_resp[1], b_resp[0]}, 64'd0);

        // Single write M0 -> S0; S1 untouched. Leaves S0's pointer at M1.
        snap_aw0 = aw_cnt[0]; snap_act1 = act_cnt[1];
        run_writes(2'b01, 32'h0000_0000, 32'h0, 4'd0, 4'd0, 32'hDEAD_BEEF, 32'h0);
        chk("single_aw", aw_cnt[0] - snap_aw0, 64'd1);
        chk("single_addr", aw_addr_q[0], 64'h0);
        chk("single_data", wdata_q[0], 64'hDEAD_BEEF);
        chk("single_resp", b_resp[0], 64'd0);
        chk("single_s1_idle", act_cnt[1] - snap_act1, 64'd0);
        chk("single_arb_lat", aw_cyc[0] - start_cyc, 64'd1);
        chk("single_total_cycles", b_cyc[0] - start_cyc + 1, 64'd4);

        // Contention repeated: pointer now favours M1.
        run_writes(2'b11, 32'h0000_0020, 32'h0000_0030, 4'd0, 4'd0, 32'hA1, 32'hB1);
        chk("cont2_m1_first", {63'd0, aw_cyc[1] < aw_cyc[0]}, 64'd1);
        chk("cont2_m0_gap", aw_cyc[0], b_cyc[1] + 2);

        // 4-beat burst M1 -> S1.
        snap_beat = beat_cnt[1]; snap_last = last_cnt[1]; snap_b = b_cnt[1];
        run_writes(2'b10, 32'h0, 32'h1000_0040, 4'd0, 4'd3, 32'h0, 32'h1);
        chk("burst_beats", beat_cnt[1] - snap_beat, 64'd4);
        chk("burst_wlast_count", last_cnt[1] - snap_last, 64'd1);
        chk("burst_wlast_pos", seen_len[1], 64'd4);
        chk("burst_last_data", wdata_q[1], 64'h4);
        chk("burst_awlen", aw_len_q[1], 64'd3);
        chk("burst_one_b", b_cnt[1] - snap_b, 64'd1);
        chk("burst_resp", b_resp[1], 64'd0);

        // Parallel M0 -> S0 and M1 -> S1.
        run_writes(2'b11, 32'h0000_0100, 32'h1000_0200, 4'd0, 4'd0, 32'h11, 32'h22);
        chk("par_aw_same_cycle", aw_cyc[0], aw_cyc[1]);
        chk("par_resp", {b_resp[1], b_resp[0]}, 64'd0);
        chk("par_data", {wdata_q[1], wdata_q[0]}, {32'h22, 32'h11});

        // Unmapped address from M0.
        snap_aw1 = aw_cnt[1]; snap_act0 = act_cnt[0]; snap_act1 = act_cnt[1];
        run_writes(2'b01, 32'hF000_0000, 32'h0, 4'd0, 4'd0, 32'h55, 32'h0);
`ifdef AXI3_WR_XBAR_DECERR_EN
        chk("unmapped_resp", b_resp[0], 64'd3);
        chk("unmapped_no_slave", (act_cnt[0] - snap_act0) + (act_cnt[1] - snap_act1), 64'd0);
`else
        chk("unmapped_resp", b_resp[0], 64'd0);
        chk("unmapped_on_s1", aw_cnt[1] - snap_aw1, 64'd1);
        chk("unmapped_addr", aw_addr_q[1], 64'hF000_0000);
`endif

        // Reset during beat 2 of a 4-beat burst M0 -> S0.
        snap_beat = beat_cnt[0]; snap_b0 = b_cnt[0];
        @(negedge ACLK);
        M_AWADDR[31:0] = 32'h0000_0040; M_AWLEN[3:0] = 4'd3; M_AWSIZE[2:0] = 3'd2;
        M_AWBURST[1:0] = 2'b01; M_AWVALID[0] = 1'b1;
        M_WDATA[31:0] = 32'h1; M_WSTRB[3:0] = 4'hF; M_WLAST[0] = 1'b0; M_WVALID[0] = 1'b1;
        @(posedge ACLK); #1;
        @(posedge ACLK); #1; M_AWVALID[0] = 1'b0;
        @(posedge ACLK); #1; M_WDATA[31:0] = 32'h2;
        ARESETn = 1'b0;
        @(negedge ACLK);
        chk_idle("midburst_reset");
        chk("midburst_beats_before", beat_cnt[0] - snap_beat, 64'd1);
        clear_masters();
        @(negedge ACLK);
        ARESETn = 1'b1;
        repeat (2) @(negedge ACLK);
        chk("midburst_no_b", b_cnt[0] - snap_b0, 64'd0);

        // Fresh single write after reset.
        run_writes(2'b01, 32'h0000_0010, 32'h0, 4'd0, 4'd0, 32'h1234_5678, 32'h0);
        chk("post_reset_resp", b_resp[0], 64'd0);
        chk("post_reset_data", wdata_q[0], 64'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
